// File: rtl/svm_pkg.sv
// Shared definitions for the SVM stream driver.
// Holds the driver state encoding, the default parameter widths and the
// fixed lengths of the START and ALPHA phases.
package svm_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_ALPHA,
    S_WEIGHTS,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } svm_state_t;

  localparam int DEF_NSVS      = 6;
  localparam int DEF_ALPHA_BW  = 16;
  localparam int DEF_DATA_BW   = 16;
  localparam int DEF_WEIGHT_BW = 16;
  localparam int DEF_CNT_BW    = 16;

  localparam int START_CYCLES  = 1;
  localparam int ALPHA_CYCLES  = 1;

endpackage

// File: rtl/svm_weight_buf.sv
// Weight buffer: nSVs x weight_BW register file.
// Ports:
//   clk, reset    : clock, synchronous active-low reset (clears all slots)
//   wr_en/wr_idx/wr_data : write port, one slot per cycle
//   rd_idx/rd_data       : independent asynchronous read port
module svm_weight_buf #(
  parameter int nSVs      = 6,
  parameter int weight_BW = 16,
  parameter int IDX_W     = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [IDX_W-1:0]     wr_idx,
  input  logic [weight_BW-1:0] wr_data,
  input  logic [IDX_W-1:0]     rd_idx,
  output logic [weight_BW-1:0] rd_data
);

  logic [weight_BW-1:0] mem [nSVs];

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < nSVs; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/svm_stream_driver.sv
// SVM stream driver: loads nSVs weights from the host, then sequences the
// classifier through START, ALPHA, a burst of weights and a stream of test
// points, collects the returned labels and signals completion.
// Ports:
//   clk, reset              : clock, synchronous active-low reset
//   run, num_test           : start pulse (accepted in IDLE) and point count
//   w_valid/w_ready/w_data  : host weight load handshake
//   s_valid/s_ready/s_x/s_y : host test-point handshake
//   svm_start, svm_DE_in, svm_weight, svm_data_x, svm_data_y : classifier drive
//   svm_DE_out, svm_label   : classifier result stream
//   lbl_valid, lbl_data, lbl_count : registered labels and saturating count
//   busy, done              : status (done pulses one cycle per finished run)
//   pos_count               : only when SVM_DRV_POSCNT_EN is defined; count of
//                             labels equal to 1 in the current run
module svm_stream_driver
  import svm_pkg::*;
#(
  parameter int nSVs      = DEF_NSVS,
  parameter int alpha_BW  = DEF_ALPHA_BW,
  parameter int data_BW   = DEF_DATA_BW,
  parameter int weight_BW = DEF_WEIGHT_BW,
  parameter int CNT_BW    = DEF_CNT_BW
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run,
  input  logic [CNT_BW-1:0]    num_test,
  input  logic                 w_valid,
  output logic                 w_ready,
  input  logic [weight_BW-1:0] w_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [data_BW-1:0]   s_x,
  input  logic [data_BW-1:0]   s_y,
  output logic                 svm_start,
  output logic                 svm_DE_in,
  output logic [weight_BW-1:0] svm_weight,
  output logic [data_BW-1:0]   svm_data_x,
  output logic [data_BW-1:0]   svm_data_y,
  input  logic                 svm_DE_out,
  input  logic                 svm_label,
  output logic                 lbl_valid,
  output logic                 lbl_data,
  output logic [CNT_BW-1:0]    lbl_count,
  output logic                 busy,
  output logic                 done
`ifdef SVM_DRV_POSCNT_EN
  ,
  output logic [CNT_BW-1:0]    pos_count
`endif
);

  localparam int IDX_W = (nSVs > 1) ? $clog2(nSVs) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(nSVs - 1);
  localparam logic [IDX_W-1:0] START_LAST = IDX_W'(START_CYCLES - 1);
  localparam logic [IDX_W-1:0] ALPHA_LAST = IDX_W'(ALPHA_CYCLES - 1);

  // No alpha datapath is driven by this block; the width is only validated.
  if (alpha_BW < 1 || data_BW < 1 || weight_BW < 1 || CNT_BW < 1 || nSVs < 1) begin : g_bad_param
    $error("svm_stream_driver: all widths and nSVs must be at least 1");
  end

  function automatic logic [CNT_BW-1:0] sat_inc(input logic [CNT_BW-1:0] v);
    return (&v) ? v : v + CNT_BW'(1);
  endfunction

  svm_state_t           state;
  logic [CNT_BW-1:0]    num_reg;
  logic [CNT_BW-1:0]    scnt;
  logic [IDX_W-1:0]     wcnt;     // load slot, phase length and weight index
  logic                 seen_hi;  // DE_out observed high during this run
  logic [IDX_W-1:0]     rd_idx;
  logic [weight_BW-1:0] rd_data;
  logic                 run_acc;

  assign run_acc   = (state == S_IDLE) && run;
  assign w_ready   = (state == S_LOAD);
  assign s_ready   = (state == S_STREAM);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign svm_start = (state != S_IDLE) && (state != S_LOAD);

  // Prefetch the next slot so svm_weight is registered yet gap-free:
  // slot 0 is captured leaving ALPHA, slot i+1 during WEIGHTS cycle i.
  assign rd_idx = (state == S_WEIGHTS && wcnt != IDX_LAST) ? wcnt + IDX_W'(1) : '0;

  svm_weight_buf #(
    .nSVs      (nSVs),
    .weight_BW (weight_BW),
    .IDX_W     (IDX_W)
  ) u_buf (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (w_ready && w_valid),
    .wr_idx  (wcnt),
    .wr_data (w_data),
    .rd_idx  (rd_idx),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= S_IDLE;
      num_reg    <= '0;
      scnt       <= '0;
      wcnt       <= '0;
      seen_hi    <= 1'b0;
      svm_DE_in  <= 1'b0;
      svm_weight <= '0;
      svm_data_x <= '0;
      svm_data_y <= '0;
    end else begin
      svm_DE_in <= 1'b0;
      case (state)
        S_IDLE: begin
          if (run) begin
            num_reg <= num_test;
            scnt    <= '0;
            wcnt    <= '0;
            seen_hi <= 1'b0;
            state   <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (w_valid) begin
            if (wcnt == IDX_LAST) begin
              wcnt  <= '0;
              state <= S_START;
            end else begin
              wcnt <= wcnt + IDX_W'(1);
            end
          end
        end
        S_START: begin
          if (wcnt == START_LAST) begin
            wcnt  <= '0;
            state <= S_ALPHA;
          end else begin
            wcnt <= wcnt + IDX_W'(1);
          end
        end
        S_ALPHA: begin
          if (wcnt == ALPHA_LAST) begin
            wcnt       <= '0;
            svm_weight <= rd_data;
            state      <= S_WEIGHTS;
          end else begin
            wcnt <= wcnt + IDX_W'(1);
          end
        end
        S_WEIGHTS: begin
          if (wcnt == IDX_LAST) begin
            wcnt  <= '0;
            state <= (num_reg == '0) ? S_DONE : S_STREAM;
          end else begin
            wcnt       <= wcnt + IDX_W'(1);
            svm_weight <= rd_data;
          end
        end
        S_STREAM: begin
          if (svm_DE_out) seen_hi <= 1'b1;
          if (s_valid) begin
            svm_DE_in  <= 1'b1;
            svm_data_x <= s_x;
            svm_data_y <= s_y;
            if (scnt == num_reg - CNT_BW'(1)) begin
              scnt  <= '0;
              state <= S_DRAIN;
            end else begin
              scnt <= scnt + CNT_BW'(1);
            end
          end
        end
        S_DRAIN: begin
          if (svm_DE_out) seen_hi <= 1'b1;
          else if (seen_hi) state <= S_DONE;
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Label capture: one-cycle registered copy of the classifier result stream.
  always_ff @(posedge clk) begin
    if (!reset) begin
      lbl_valid <= 1'b0;
      lbl_data  <= 1'b0;
      lbl_count <= '0;
    end else begin
      lbl_valid <= svm_DE_out;
      lbl_data  <= svm_label;
      if (run_acc)        lbl_count <= '0;
      else if (lbl_valid) lbl_count <= sat_inc(lbl_count);
    end
  end

`ifdef SVM_DRV_POSCNT_EN
  always_ff @(posedge clk) begin
    if (!reset)                       pos_count <= '0;
    else if (run_acc)                 pos_count <= '0;
    else if (lbl_valid && lbl_data)   pos_count <= sat_inc(pos_count);
  end
`endif

endmodule

// File: tb/tb_svm_stream_driver.sv
module tb_svm_stream_driver;

  localparam int NSV = 6;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic [15:0] num_test;
  logic        w_valid;
  logic        w_ready;
  logic [15:0] w_data;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] s_x;
  logic [15:0] s_y;
  logic        svm_start;
  logic        svm_DE_in;
  logic [15:0] svm_weight;
  logic [15:0] svm_data_x;
  logic [15:0] svm_data_y;
  logic        svm_DE_out;
  logic        svm_label;
  logic        lbl_valid;
  logic        lbl_data;
  logic [15:0] lbl_count;
  logic        busy;
  logic        done;
`ifdef SVM_DRV_POSCNT_EN
  logic [15:0] pos_count;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  svm_stream_driver dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .num_test   (num_test),
    .w_valid    (w_valid),
    .w_ready    (w_ready),
    .w_data     (w_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_x        (s_x),
    .s_y        (s_y),
    .svm_start  (svm_start),
    .svm_DE_in  (svm_DE_in),
    .svm_weight (svm_weight),
    .svm_data_x (svm_data_x),
    .svm_data_y (svm_data_y),
    .svm_DE_out (svm_DE_out),
    .svm_label  (svm_label),
    .lbl_valid  (lbl_valid),
    .lbl_data   (lbl_data),
    .lbl_count  (lbl_count),
    .busy       (busy),
    .done       (done)
`ifdef SVM_DRV_POSCNT_EN
    ,
    .pos_count  (pos_count)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Accept a run, load NSV weights base..base+NSV-1 (optionally with one
  // w_valid gap), and walk START, ALPHA and WEIGHTS checking each cycle.
  task automatic go_stream(input int n, input int base, input bit gap);
    run = 1'b1; num_test = 16'(n);
    tick();
    run = 1'b0;
    chk("busy_load", busy, 1);
    chk("w_ready_load", w_ready, 1);
    for (int i = 0; i < NSV; i++) begin
      if (gap && i == 2) begin
        w_valid = 1'b0;
        tick();
        chk("w_ready_gap", w_ready, 1);
      end
      w_valid = 1'b1; w_data = 16'(base + i);
      chk("start_pre", svm_start, 0);
      tick();
    end
    w_valid = 1'b0;
    chk("start_rise", svm_start, 1);
    chk("w_ready_off", w_ready, 0);
    tick();
    chk("start_alpha", svm_start, 1);
    tick();
    for (int k = 0; k < NSV; k++) begin
      chk("weight_seq", svm_weight, 32'(16'(base + k)));
      chk("de_in_weights", svm_DE_in, 0);
      tick();
    end
  endtask

  initial begin
    reset = 1'b0; run = 1'b0; num_test = '0; w_valid = 1'b0; w_data = '0;
    s_valid = 1'b0; s_x = '0; s_y = '0; svm_DE_out = 1'b0; svm_label = 1'b0;
    tick(); tick(); tick();

    // Reset state
    chk("rst_busy", busy, 0);
    chk("rst_start", svm_start, 0);
    chk("rst_w_ready", w_ready, 0);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_weight", svm_weight, 0);
    chk("rst_lbl_count", lbl_count, 0);
    chk("rst_done", done, 0);
    reset = 1'b1;
    tick();

    // Run 1: weights 1..6, three contiguous points, labels 1,0,1
    go_stream(3, 1, 1'b0);
    chk("weight_hold", svm_weight, 6);
    for (int p = 0; p < 3; p++) begin
      s_valid = 1'b1; s_x = 16'(10 + p); s_y = 16'(20 + p);
      chk("s_ready_stream", s_ready, 1);
      tick();
      chk("de_in_contig", svm_DE_in, 1);
      chk("data_x", svm_data_x, 32'(10 + p));
      chk("data_y", svm_data_y, 32'(20 + p));
    end
    s_valid = 1'b0;
    chk("s_ready_drop", s_ready, 0);
    tick();
    chk("de_in_after", svm_DE_in, 0);
    svm_DE_out = 1'b1; svm_label = 1'b1; tick();
    chk("lbl_valid", lbl_valid, 1);
    chk("lbl_data_1", lbl_data, 1);
    svm_label = 1'b0; tick();
    chk("lbl_data_0", lbl_data, 0);
    svm_label = 1'b1; tick();
    chk("done_early", done, 0);
    svm_DE_out = 1'b0; svm_label = 1'b0; tick();
    chk("done_pulse", done, 1);
    chk("lbl_count_3", lbl_count, 3);
`ifdef SVM_DRV_POSCNT_EN
    chk("pos_count_2", pos_count, 2);
`endif
    tick();
    chk("done_once", done, 0);
    chk("idle_busy", busy, 0);

    // Run 2: weights 0x20.. with a load gap; s_valid 1,0,1,1; run ignored in STREAM
    go_stream(3, 32, 1'b1);
    chk("lbl_count_clr", lbl_count, 0);
    s_valid = 1'b1; s_x = 16'd1; s_y = 16'd2; tick();
    chk("pat_de0", svm_DE_in, 1);
    s_valid = 1'b0; run = 1'b1; num_test = 16'd1; tick();
    run = 1'b0;
    chk("pat_de1", svm_DE_in, 0);
    chk("pat_hold_x", svm_data_x, 1);
    chk("run_ignored_busy", busy, 1);
    chk("run_ignored_ready", s_ready, 1);
    s_valid = 1'b1; s_x = 16'd3; s_y = 16'd4; tick();
    chk("pat_de2", svm_DE_in, 1);
    chk("pat_x2", svm_data_x, 3);
    s_valid = 1'b1; s_x = 16'd5; s_y = 16'd6;
    chk("num_test_kept", s_ready, 1);
    tick();
    s_valid = 1'b0;
    chk("pat_de3", svm_DE_in, 1);
    chk("pat_y3", svm_data_y, 6);
    chk("pat_ready_drop", s_ready, 0);
    svm_DE_out = 1'b1; svm_label = 1'b1; tick();
    svm_DE_out = 1'b0; svm_label = 1'b0; tick();
    chk("done_run2", done, 1);
    chk("lbl_count_1", lbl_count, 1);
`ifdef SVM_DRV_POSCNT_EN
    chk("pos_count_1", pos_count, 1);
`endif
    tick();

    // Run 3: num_test = 0 goes from WEIGHTS straight to DONE
    go_stream(0, 64, 1'b0);
    chk("zero_done", done, 1);
    chk("zero_de_in", svm_DE_in, 0);
    chk("zero_s_ready", s_ready, 0);
    chk("zero_lbl_count", lbl_count, 0);
    tick();
    chk("zero_idle", busy, 0);

    // Run 4: reset mid-STREAM after two points
    go_stream(3, 80, 1'b0);
    for (int p = 0; p < 2; p++) begin
      s_valid = 1'b1; s_x = 16'(7 + p); s_y = 16'(9 + p); tick();
    end
    s_valid = 1'b0;
    chk("pre_abort_x", svm_data_x, 8);
    reset = 1'b0; tick();
    chk("abort_busy", busy, 0);
    chk("abort_start", svm_start, 0);
    chk("abort_done", done, 0);
    chk("abort_de_in", svm_DE_in, 0);
    chk("abort_x", svm_data_x, 0);
    chk("abort_y", svm_data_y, 0);
    chk("abort_weight", svm_weight, 0);
    chk("abort_s_ready", s_ready, 0);
    reset = 1'b1; tick();
    chk("abort_no_done", done, 0);

    // Run 5: normal completion after the abort
    go_stream(2, 256, 1'b0);
    for (int p = 0; p < 2; p++) begin
      s_valid = 1'b1; s_x = 16'(40 + p); s_y = 16'(50 + p); tick();
      chk("rerun_de_in", svm_DE_in, 1);
    end
    s_valid = 1'b0;
    chk("rerun_drain", s_ready, 0);
    svm_DE_out = 1'b1; svm_label = 1'b0; tick();
    tick();
    svm_DE_out = 1'b0; tick();
    chk("rerun_done", done, 1);
    chk("rerun_lbl_count", lbl_count, 2);
`ifdef SVM_DRV_POSCNT_EN
    chk("rerun_pos_count", pos_count, 0);
`endif
    tick();
    chk("rerun_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/svm_stream_driver.md
SVM_STREAM_DRIVER -- requirements
Module: svm_stream_driver

Interface
REQ-001 Parameter nSVs, default 6, number of support vectors and weights per run.
REQ-002 Parameter alpha_BW, default 16, alpha width.
REQ-003 Parameter data_BW, default 16, width of each test-point coordinate.
REQ-004 Parameter weight_BW, default 16, weight width.
REQ-005 Parameter CNT_BW, default 16, width of the test-point and label counters.
REQ-006 Port clk, input, 1, the single clock; all logic is rising-edge.
REQ-007 Port reset, input, 1, synchronous active-low reset (0 = reset, sampled on clk).
REQ-008 Ports run / num_test, inputs, 1 / CNT_BW: pulse to begin a run; number of test points in the run.
REQ-009 Ports w_valid / w_ready / w_data, in / out / in, 1 / 1 / weight_BW: host weight load handshake.
REQ-010 Ports s_valid / s_ready / s_x / s_y, in / out / in / in, 1 / 1 / data_BW / data_BW: host test-point handshake.
REQ-011 Ports svm_start / svm_DE_in / svm_weight / svm_data_x / svm_data_y, outputs, 1 / 1 / weight_BW / data_BW / data_BW: classifier-side drive.
REQ-012 Ports svm_DE_out / svm_label, inputs, 1 / 1: classifier result stream.
REQ-013 Ports lbl_valid / lbl_data / lbl_count / busy / done, outputs, 1 / 1 / CNT_BW / 1 / 1: label sink and status.

Function
REQ-014 States: IDLE, LOAD, START, ALPHA, WEIGHTS, STREAM, DRAIN, DONE.
REQ-015 IDLE: a run=1 pulse loads num_test into an internal register and moves to LOAD; run is ignored outside IDLE.
REQ-016 LOAD: w_ready=1; each w_valid&w_ready handshake writes w_data into buffer slot 0..nSVs-1 in order; after the nSVs-th handshake, move to START.
REQ-017 START lasts 1 cycle and ALPHA lasts 1 cycle; svm_start=1 from START entry until DONE exits, otherwise 0.
REQ-018 WEIGHTS lasts exactly nSVs consecutive cycles and drives buffer slot i on svm_weight in cycle i, with no gaps; svm_weight holds its last value afterwards.
REQ-019 STREAM: s_ready=1; svm_DE_in registers (s_valid&s_ready), and svm_data_x/svm_data_y register s_x/s_y on each handshake.
REQ-020 STREAM: gaps in s_valid give svm_DE_in=0 cycles, with the data outputs held; on the num_test-th handshake s_ready drops the same cycle it fires, and the state moves to DRAIN.
REQ-021 num_test=0: WEIGHTS goes directly to DONE, with no DE_in activity.
REQ-022 DRAIN: wait until svm_DE_out has been seen high, then low; then go to DONE.
REQ-023 DONE lasts 1 cycle with done=1, then returns to IDLE.
REQ-024 Labels: lbl_valid=svm_DE_out and lbl_data=svm_label, registered with 1-cycle latency; lbl_count increments per lbl_valid, clears on run acceptance, and saturates at all-ones.
REQ-025 busy=1 in every state except IDLE.
REQ-026 w_ready=0 outside LOAD; s_ready=0 outside STREAM.

Reset
REQ-027 While reset=0 at a clk edge: state←IDLE; svm_start, svm_DE_in, w_ready, s_ready, lbl_valid, lbl_data, busy, done all 0; svm_weight, svm_data_x, svm_data_y, lbl_count, buffer, counters all 0.
REQ-028 Reset asserted mid-run aborts immediately; no done pulse is issued for the aborted run.

Configuration
REQ-029 With SVM_DRV_POSCNT_EN defined: extra output pos_count (CNT_BW) counts lbl_valid cycles with lbl_data=1, clears on run acceptance, saturates, and is reset to 0.
REQ-030 With SVM_DRV_POSCNT_EN undefined: the pos_count port and its logic are absent, and all other behaviour is identical.

Structure
REQ-031 Shared package svm_pkg holds the state enum, the default width constants, and the ALPHA_CYCLES=1 and START_CYCLES=1 constants.
REQ-032 One sub-module, svm_weight_buf: an nSVs x weight_BW register file with a write port and an independent read index.

Verification
REQ-033 Load weights 1..6, num_test=3, 3 contiguous points → svm_start rises 1 cycle after the 6th w handshake; weights 1..6 appear on 6 consecutive cycles starting 2 cycles after svm_start; DE_in high for 3 cycles.
REQ-034 s_valid pattern 1,0,1,1 with num_test=3 → DE_in pattern 1,0,1,1 (delayed 1 cycle); 4th-cycle s_ready=0 after the 3rd handshake.
REQ-035 Model returns DE_out high for 3 cycles with labels 1,0,1 → lbl_count=3, done pulses once after DE_out falls, with SVM_DRV_POSCNT_EN pos_count=2.
REQ-036 num_test=0 → DONE follows WEIGHTS directly; DE_in never rises; lbl_count=0.
REQ-037 Reset driven low during STREAM after 2 points → all outputs 0 next cycle, no done; a new run completes normally.
REQ-038 run pulsed during STREAM → ignored; num_test and counters unchanged.
